// File: rtl/rr_priority_encoder.sv
// Registered priority encoder: sticky request capture, fixed or round-robin grant selection, valid/ready output.
// Optional macro RR_PRIORITY_ENCODER_ONEHOT_EN adds a registered one-hot copy of the grant (out_onehot).
module rr_priority_encoder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             mode_rr,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef RR_PRIORITY_ENCODER_ONEHOT_EN
  output logic [WIDTH-1:0] out_onehot,
`endif
  output logic [WIDTH-1:0] pending,
  output logic [CNT_W-1:0] merge_cnt
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [WIDTH-1:0] ONE_BIT = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_pending, w_pending_next;
  logic [IDX_W-1:0] r_out_idx, w_idx_next;
  logic [IDX_W-1:0] r_rr_ptr, w_ptr_next;
  logic [CNT_W-1:0] r_merge_cnt, w_cnt_next;
  logic             r_out_valid, r_req_ready;
  logic             w_accept, w_do_sel;
  logic [WIDTH-1:0] w_req, w_clear, w_merge;
  logic [IDX_W-1:0] w_rr_base, w_sel;
  logic [CNT_W+6:0] w_sum;

  function automatic logic [IDX_W-1:0] fixed_pick(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] p;
    p = {IDX_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) p = IDX_W'(i);
    end
    return p;
  endfunction

  // Walk downward in distance so the nearest set bit above base is the last one written.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [WIDTH-1:0] v, input logic [IDX_W-1:0] base);
    logic [IDX_W-1:0] p;
    int               j;
    p = {IDX_W{1'b0}};
    for (int k = WIDTH; k >= 1; k--) begin
      j = (int'(base) + k) % WIDTH;
      if (v[j]) p = IDX_W'(j);
    end
    return p;
  endfunction

  function automatic logic [6:0] popcount(input logic [WIDTH-1:0] v);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  assign w_accept  = req_valid & r_req_ready;
  assign w_req     = w_accept ? req_in : {WIDTH{1'b0}};
  // A completing grant becomes the new round-robin pointer for the back-to-back pick.
  assign w_rr_base = (r_state == PRESENT) ? r_out_idx : r_rr_ptr;
  assign w_sel     = mode_rr ? rr_pick(r_pending, w_rr_base) : fixed_pick(r_pending);

  // Next-state, selection and capture logic.
  always_comb begin
    w_state_next = r_state;
    w_do_sel     = 1'b0;
    w_ptr_next   = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_do_sel     = 1'b1;
          w_state_next = PRESENT;
        end else begin
          w_state_next = IDLE;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          w_ptr_next = r_out_idx;
          if (|r_pending) begin
            w_do_sel     = 1'b1;
            w_state_next = PRESENT;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_state_next = PRESENT;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_do_sel) begin
      w_clear    = ONE_BIT << w_sel;
      w_idx_next = w_sel;
    end else begin
      w_clear    = {WIDTH{1'b0}};
      w_idx_next = r_out_idx;
    end

    w_pending_next = (r_pending & ~w_clear) | w_req;
    w_merge        = w_req & r_pending & ~w_clear;
    w_sum          = {7'd0, r_merge_cnt} + {{CNT_W{1'b0}}, popcount(w_merge)};
    if (w_sum > {7'd0, CNT_MAX}) begin
      w_cnt_next = CNT_MAX;
    end else begin
      w_cnt_next = w_sum[CNT_W-1:0];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= {WIDTH{1'b0}};
      r_out_idx   <= {IDX_W{1'b0}};
      r_out_valid <= 1'b0;
      r_merge_cnt <= {CNT_W{1'b0}};
      r_req_ready <= 1'b0;
      r_rr_ptr    <= IDX_W'(WIDTH - 1);
    end else begin
      r_state     <= w_state_next;
      r_pending   <= w_pending_next;
      r_out_idx   <= w_idx_next;
      r_out_valid <= (w_state_next == PRESENT);
      r_merge_cnt <= w_cnt_next;
      r_req_ready <= 1'b1;
      r_rr_ptr    <= w_ptr_next;
    end
  end

`ifdef RR_PRIORITY_ENCODER_ONEHOT_EN
  logic [WIDTH-1:0] r_onehot;

  // One-hot mirror of the grant, loaded alongside out_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_onehot <= {WIDTH{1'b0}};
    end else if (w_state_next == PRESENT) begin
      r_onehot <= ONE_BIT << w_idx_next;
    end else begin
      r_onehot <= {WIDTH{1'b0}};
    end
  end

  assign out_onehot = r_onehot;
`endif

  assign req_ready = r_req_ready;
  assign out_idx   = r_out_idx;
  assign out_valid = r_out_valid;
  assign pending   = r_pending;
  assign merge_cnt = r_merge_cnt;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Self-checking bench for rr_priority_encoder (WIDTH=8): directed scenarios plus randomized traffic vs a behavioural model.
module tb_rr_priority_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic       req_valid;
  logic       req_ready;
  logic       mode_rr;
  logic [2:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic [7:0] merge_cnt;
`ifdef RR_PRIORITY_ENCODER_ONEHOT_EN
  logic [7:0] out_onehot;
`endif

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  bit [7:0] m_pending;
  bit       m_valid;
  int       m_idx;
  int       m_ptr;
  int       m_cnt;
  bit       m_ready;

  always #5 clk = ~clk;

  rr_priority_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mode_rr   (mode_rr),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef RR_PRIORITY_ENCODER_ONEHOT_EN
    .out_onehot(out_onehot),
`endif
    .pending   (pending),
    .merge_cnt (merge_cnt)
  );

  // Grant choice from the selection rules: fixed = highest set bit; rr = first set bit after base, wrapping.
  function automatic int pick(bit [7:0] v, int base, bit rr);
    int p;
    p = -1;
    if (!rr) begin
      for (int b = 0; b < 8; b++) if (v[b]) p = b;
    end else begin
      for (int off = 1; off <= 8; off++) if (p < 0 && v[(base + off) % 8]) p = (base + off) % 8;
    end
    return p;
  endfunction

  // Advance model by one clock using the inputs currently applied, then clock the DUT.
  task automatic tick();
    bit [7:0] r;
    int       s;
    int       merges;
    bit       sel;
    if (rst) begin
      m_pending = 8'h00; m_valid = 1'b0; m_idx = 0; m_cnt = 0; m_ready = 1'b0; m_ptr = 7;
    end else begin
      r = (req_valid && m_ready) ? req_in : 8'h00;
      sel = 1'b0; s = 0; merges = 0;
      if (!m_valid) begin
        if (m_pending != 8'h00) begin s = pick(m_pending, m_ptr, mode_rr); sel = 1'b1; end
      end else if (out_ready) begin
        m_ptr = m_idx;
        if (m_pending != 8'h00) begin s = pick(m_pending, m_idx, mode_rr); sel = 1'b1; end
        else m_valid = 1'b0;
      end
      for (int b = 0; b < 8; b++) if (r[b] && m_pending[b] && !(sel && b == s)) merges++;
      if (sel) begin m_pending[s] = 1'b0; m_idx = s; m_valid = 1'b1; end
      m_pending = m_pending | r;
      m_cnt = (m_cnt + merges > 255) ? 255 : m_cnt + merges;
      m_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = 1'b0; req_in = 8'h00; out_ready = 1'b0; mode_rr = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_in = 8'hFF; out_ready = 1'b0; mode_rr = 1'b0;
    tick(); tick();
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready got %0b want 0", req_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_vec++; if (pending !== 8'h00) begin n_err++; $display("FAIL reset_pending got %h want 00", pending); end
    n_vec++; if (merge_cnt !== 8'd0) begin n_err++; $display("FAIL reset_merge_cnt got %0d want 0", merge_cnt); end
    n_vec++; if (out_idx !== 3'd0) begin n_err++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
    rst = 1'b0; req_valid = 1'b0;
    tick();
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_req_ready got %0b want 1", req_ready); end
    n_vec++; if (out_valid !== 1'b0 || pending !== 8'h00) begin
      n_err++; $display("FAIL post_reset_idle got valid=%0b pending=%h want 0/00", out_valid, pending); end
  endtask

  task automatic test_fixed_burst();
    int exp_seq[3] = '{5, 3, 0};
    apply_reset();
    mode_rr = 1'b0; out_ready = 1'b1; req_valid = 1'b1; req_in = 8'h29;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_idx !== 3'(exp_seq[i])) begin
        n_err++; $display("FAIL fixed_burst[%0d] got valid=%0b idx=%0d want 1/%0d", i, out_valid, out_idx, exp_seq[i]); end
    end
    tick();
    n_vec++; if (out_valid !== 1'b0 || pending !== 8'h00) begin
      n_err++; $display("FAIL fixed_burst_end got valid=%0b pending=%h want 0/00", out_valid, pending); end
  endtask

  task automatic test_rr_fairness();
    int hist[8];
    int g;
    apply_reset();
    mode_rr = 1'b1; out_ready = 1'b1; req_valid = 1'b1; req_in = 8'hFF;
    for (int i = 0; i < 8; i++) hist[i] = 0;
    g = 0;
    tick();
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        n_vec++; if (out_idx !== 3'(g % 8) || out_idx !== 3'(m_idx)) begin
          n_err++; $display("FAIL rr_seq[%0d] got idx=%0d want %0d", g, out_idx, g % 8); end
        if (g < 8) hist[out_idx]++;
        g++;
      end
    end
    n_vec++; if (g != 12) begin n_err++; $display("FAIL rr_grant_rate got %0d grants want 12", g); end
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (hist[i] != 1) begin n_err++; $display("FAIL rr_hist[%0d] got %0d want 1", i, hist[i]); end
    end
    req_valid = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    n_vec++; if (out_valid !== 1'b0 || pending !== 8'h00) begin
      n_err++; $display("FAIL rr_drain got valid=%0b pending=%h want 0/00", out_valid, pending); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    mode_rr = 1'b0; out_ready = 1'b0; req_valid = 1'b1; req_in = 8'h80;
    tick();
    req_valid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_idx !== 3'd7) begin
        n_err++; $display("FAIL backpressure_hold[%0d] got valid=%0b idx=%0d want 1/7", c, out_valid, out_idx); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL backpressure_release got valid=%0b want 0", out_valid); end
  endtask

  task automatic test_merge();
    apply_reset();
    mode_rr = 1'b0; out_ready = 1'b0; req_valid = 1'b1; req_in = 8'h80;
    tick();
    req_in = 8'h01;
    tick();
    tick();
    req_valid = 1'b0;
    tick();
    n_vec++; if (merge_cnt !== 8'd1 || out_idx !== 3'd7 || pending !== 8'h01) begin
      n_err++; $display("FAIL merge_one got cnt=%0d idx=%0d pending=%h want 1/7/01", merge_cnt, out_idx, pending); end
    req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      n_vec++; if (merge_cnt !== 8'(m_cnt)) begin
        n_err++; $display("FAIL merge_track[%0d] got %0d want %0d", i, merge_cnt, m_cnt); end
    end
    n_vec++; if (merge_cnt !== 8'd255) begin n_err++; $display("FAIL merge_saturate got %0d want 255", merge_cnt); end
    req_valid = 1'b0;
  endtask

  task automatic test_rerequest_reset();
    apply_reset();
    mode_rr = 1'b0; out_ready = 1'b1; req_valid = 1'b1; req_in = 8'h08;
    tick();
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_idx !== 3'd3 || pending !== 8'h08 || merge_cnt !== 8'd0) begin
      n_err++; $display("FAIL rereq_select got valid=%0b idx=%0d pending=%h cnt=%0d want 1/3/08/0",
                        out_valid, out_idx, pending, merge_cnt); end
    req_valid = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_idx !== 3'd3 || pending !== 8'h00) begin
      n_err++; $display("FAIL rereq_second got valid=%0b idx=%0d pending=%h want 1/3/00", out_valid, out_idx, pending); end
    out_ready = 1'b0; req_valid = 1'b1; req_in = 8'h41;
    tick();
    req_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || pending !== 8'h00 || req_ready !== 1'b0) begin
      n_err++; $display("FAIL midop_reset got valid=%0b pending=%h ready=%0b want 0/00/0", out_valid, pending, req_ready); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(63) == 0);
      req_valid = ($urandom_range(3) != 0);
      req_in    = 8'($urandom) & 8'($urandom);
      mode_rr   = ($urandom_range(1) == 1);
      out_ready = ($urandom_range(2) != 0);
      tick();
      n_vec++; if (out_valid !== m_valid || pending !== m_pending || merge_cnt !== 8'(m_cnt) || req_ready !== m_ready) begin
        n_err++; $display("FAIL rand_state[%0d] got v=%0b p=%h c=%0d r=%0b want v=%0b p=%h c=%0d r=%0b", c,
                          out_valid, pending, merge_cnt, req_ready, m_valid, m_pending, m_cnt, m_ready); end
      if (m_valid) begin
        n_vec++; if (out_idx !== 3'(m_idx)) begin
          n_err++; $display("FAIL rand_idx[%0d] got %0d want %0d", c, out_idx, m_idx); end
      end
`ifdef RR_PRIORITY_ENCODER_ONEHOT_EN
      n_vec++; if (out_onehot !== (m_valid ? (8'h01 << m_idx) : 8'h00)) begin
        n_err++; $display("FAIL rand_onehot[%0d] got %h", c, out_onehot); end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    m_pending = 8'h00; m_valid = 1'b0; m_idx = 0; m_ptr = 7; m_cnt = 0; m_ready = 1'b0;
    test_reset();
    test_fixed_burst();
    test_rr_fairness();
    test_backpressure();
    test_merge();
    test_rerequest_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
Parametrised, registered successor to the combinational 8-bit priority encoder used in the tt_um_* top level. It accumulates request bits into a sticky pending vector and issues one granted index at a time over a valid/ready output handshake. It supports fixed-priority (MSB wins) or round-robin selection at runtime. It sits between ui_in-derived request sources and downstream consumers in the tile.

Parameters:
WIDTH, 8, number of request lines; legal range 2..64.
IDX_W, $clog2(WIDTH), index width; derived localparam, not overridable.
CNT_W, 8, width of the saturating merge counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
req_in  in  WIDTH  request bits, sampled when req_valid && req_ready.
req_valid  in  1  req_in is valid this cycle.
req_ready  out  1  block accepts requests; 0 while rst is high, otherwise 1.
mode_rr  in  1  0 = fixed priority (highest index wins); 1 = round-robin.
out_idx  out  IDX_W  granted index; stable while out_valid=1 and out_ready=0.
out_valid  out  1  out_idx holds a grant.
out_ready  in  1  consumer accepts the grant.
pending  out  WIDTH  current sticky request vector, registered.
merge_cnt  out  CNT_W  saturating count of request bits that arrived while already pending.

Behaviour:
- Reset (rst=1 at an edge):
  - pending=0, out_idx=0, out_valid=0, merge_cnt=0, req_ready=0, rr_ptr=WIDTH-1.
  - Reset mid-operation discards any presented grant and all pending bits.
- Capture:
  - On accept, pending_next = (pending & ~clear_mask) | req_in.
  - A new bit equal to the bit being cleared in the same cycle stays set; the new request wins.
  - merge_cnt += popcount(req_in & pending & ~clear_mask), saturating at 2^CNT_W-1. It never wraps.
- State machine, two states:
  - IDLE (out_valid=0): if pending != 0, select index s, register out_idx=s and out_valid=1, set clear_mask bit s, go to PRESENT. Otherwise stay in IDLE.
  - PRESENT (out_valid=1): hold out_idx. On out_ready=1, the grant completes and rr_ptr <= out_idx.
    - If (pending_next without the selection) != 0, select the next grant in the same cycle and stay in PRESENT (back-to-back, one grant per cycle).
    - Otherwise clear out_valid and go to IDLE.
- Latency: a request accepted at edge N appears on out_valid/out_idx after edge N+1 when the block is idle. Requests arriving in the same cycle as an IDLE selection are visible to the next selection only.
- Selection:
  - Fixed mode: highest set index of pending.
  - Round-robin mode: first set bit searching upward from rr_ptr+1 modulo WIDTH. rr_ptr itself is lowest priority.
  - mode_rr is sampled only at selection. Changing it never alters a presented grant.
  - rr_ptr updates on completed grants in both modes.
- Bit s is removed from pending at selection time, not at handshake. A re-request of s while s is being presented is therefore pending again and is not counted as a merge.
- No combinational path from any input to any output.

Optional Feature:
- Macro: RR_PRIORITY_ENCODER_ONEHOT_EN.
- When defined: adds output port out_onehot [WIDTH], registered with out_idx, equal to 1<<out_idx while out_valid=1 and 0 otherwise. Its reset value is 0.
- When undefined: the port and its register are absent, and all other behaviour is identical.

Test Plan:
- Reset then idle, WIDTH=8: hold rst=1 for 2 cycles, then release -> out_valid=0, pending=0x00, merge_cnt=0, req_ready=0 during reset and 1 after.
- Fixed mode burst: mode_rr=0, one accept of req_in=0x29, out_ready=1 held -> out_idx sequence 5, 3, 0 on consecutive cycles, then out_valid=0, pending=0x00.
- Round-robin fairness: mode_rr=1, req_in=0xFF accepted every cycle, out_ready=1 -> out_idx 0, 1, 2 … 7, 0. Each index is granted once per 8 grants.
- Backpressure: req_in=0x80, out_ready=0 for 5 cycles -> out_idx=7 stable and out_valid=1 throughout. Then out_ready=1 for one cycle -> out_valid=0 next cycle.
- Merge counting: send req_in=0x01 twice while bit 0 is held pending behind a stalled grant of 0x80 -> merge_cnt=1. Also force 300 merges -> merge_cnt saturates at 255.
- Same-cycle re-request plus mid-operation reset:
  - Re-request index 3 on the cycle it is selected -> pending bit 3 remains 1, and a second grant of 3 follows.
  - Assert rst while out_valid=1 -> next cycle out_valid=0 and pending=0.
